cq_sequencer: RTL and testbench
===============================

// Module: cq_sequencer
// PURPOSE
//  Dual-channel (left/right) circular sample queue feeding the FIR filter stages.
//  Stores each incoming 16-bit sample pair and keeps the newest TAPS pairs as the filter window.
//  After every new pair it replays that window, oldest first, one pair per clock under 'sequencing'.
//  The filter restarts its coefficient address and accumulators on each rising edge of 'sequencing'.
// PARAMETERS
//  DW     16    sample width, per channel
//  DEPTH  1536  storage entries, per channel
//  TAPS   1021  window length and sequence length (TAPS < DEPTH)
//  PW     $clog2(DEPTH)  pointer width (localparam)
// PORTS
//  clk         in   1    system clock, all logic on rising edge
//  rst_n       in   1    asynchronous active-low reset
//  valid       in   1    one-cycle strobe: lft_new/rght_new hold a new sample pair
//  lft_new     in   DW   new left sample, signed
//  rght_new    in   DW   new right sample, signed
//  sequencing  out  1    high for exactly TAPS consecutive cycles per replay
//  lft_smpl    out  DW   replayed left sample; 0 when sequencing=0
//  rght_smpl   out  DW   replayed right sample; 0 when sequencing=0
//  overrun     out  1    sticky lost-replay flag (CQ_OVERRUN_FLAG_EN only)
// BEHAVIOUR
//  Reset: state FILL, all pointers and counters 0, pending=0; sequencing, lft_smpl, rght_smpl, overrun = 0.
//  Writes: every valid, in any state, writes the pair at new_ptr and increments new_ptr mod DEPTH.
//    If count==TAPS at the write, old_ptr also increments mod DEPTH. Otherwise count increments.
//  States:
//    FILL: count<TAPS.
//      A valid that makes count==TAPS -> SEQ.
//    IDLE: window full, no replay in progress.
//      valid -> SEQ.
//    SEQ: on entry, rd_ptr <= old_ptr (post-write value) and seq_cnt <= 0.
//      Each cycle reads rd_ptr for both channels, then rd_ptr++ mod DEPTH and seq_cnt++.
//      After TAPS reads -> GAP.
//    GAP: exactly one cycle with sequencing=0 so the filter always sees a fresh rising edge.
//      pending=1 -> SEQ and clear pending; otherwise -> IDLE.
//  Timing: valid sampled at edge t; first read address in cycle t+1.
//    Storage read has 1-cycle registered latency, so sequencing=1 from cycle t+2 through t+TAPS+1.
//    Data is aligned with sequencing: the first sequencing cycle carries the oldest sample, the last carries the newest.
//  Valid during SEQ or GAP: the pair is written and pending is set.
//    The current replay is not disturbed: the read window is captured at entry, and writes land outside it because DEPTH-TAPS >= 515.
//  Second valid while pending=1: the pair is written and old_ptr advances, but only one more replay occurs, so one filter output is lost.
//    This is an overrun event.
//  Valid in the same cycle as the SEQ->GAP transition counts as "during SEQ".
//  Wrap-around: all pointers wrap DEPTH-1 -> 0 with no gap or duplicate.
//  Reset mid-operation: sequencing and outputs drop to 0 asynchronously, queue contents are treated as empty, and FILL restarts.
// CONFIGURATION
//  CQ_OVERRUN_FLAG_EN defined: 'overrun' port present.
//    Set on any overrun event; sticky until rst_n.
//  CQ_OVERRUN_FLAG_EN undefined: 'overrun' port and logic absent; overrun behaviour is otherwise identical.
// STRUCTURE
//  Shared package cq_pkg: typedef cq_state_t {FILL, IDLE, SEQ, GAP}; default DW/DEPTH/TAPS constants.
//  Sub-module cq_dpram: simple dual-port RAM, DEPTH x (2*DW).
//    One write port (we, waddr, wdata); one read port with registered output (raddr, rdata).
//    No reset on the array.
//  Top level holds the FSM, pointers, count/seq_cnt, pending, and output muxing to 0.
// TESTING
//  1. Feed samples L=R=1..1020 -> sequencing never rises.
//     Feed 1021 -> sequencing high 1021 cycles starting 2 cycles after the valid; lft_smpl = 1,2,...,1021.
//  2. From 1, after the replay, send valid with 1022 -> next replay = 2..1022.
//     sequencing must be low for >=1 cycle between replays.
//  3. Stream 3000 pairs with valid every 1100 cycles, L=k, R=-k.
//     Every replay is k-1020..k on both channels (R negated) across pointer wrap at 1536.
//  4. One valid (value 5000) mid-replay -> current replay unchanged.
//     One GAP cycle follows, then a replay ending in 5000. overrun stays 0.
//  5. Two valids mid-replay (6000, 6001) -> exactly one following replay, ending 6000,6001 (window shifted by 2).
//     With CQ_OVERRUN_FLAG_EN, overrun=1 and stays 1.
//  6. Assert rst_n=0 for 1 cycle at replay cycle 500 -> sequencing, outputs and overrun go to 0 at once.
//     No replay occurs until 1021 new samples arrive.

Source files
------------

// File: rtl/cq_pkg.sv
// Shared types and default sizing for the circular sample queue sequencer.
package cq_pkg;

  localparam int CQ_DW    = 16;
  localparam int CQ_DEPTH = 1536;
  localparam int CQ_TAPS  = 1021;

  // FILL: window not yet full; IDLE: full, waiting; SEQ: replaying; GAP: one quiet cycle
  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    SEQ  = 2'd2,
    GAP  = 2'd3
  } cq_state_t;

endpackage

// File: rtl/cq_sequencer_if.sv
// Sample-in / replay-out bus of cq_sequencer.
// The 'overrun' signal exists only when CQ_OVERRUN_FLAG_EN is defined.
interface cq_sequencer_if
  import cq_pkg::*;
#(
  parameter int DW = CQ_DW
);

  logic                 valid;
  logic signed [DW-1:0] lft_new;
  logic signed [DW-1:0] rght_new;
  logic                 sequencing;
  logic signed [DW-1:0] lft_smpl;
  logic signed [DW-1:0] rght_smpl;
`ifdef CQ_OVERRUN_FLAG_EN
  logic                 overrun;

  modport master (
    output valid, lft_new, rght_new,
    input  sequencing, lft_smpl, rght_smpl, overrun
  );

  modport slave (
    input  valid, lft_new, rght_new,
    output sequencing, lft_smpl, rght_smpl, overrun
  );
`else
  modport master (
    output valid, lft_new, rght_new,
    input  sequencing, lft_smpl, rght_smpl
  );

  modport slave (
    input  valid, lft_new, rght_new,
    output sequencing, lft_smpl, rght_smpl
  );
`endif

endinterface

// File: rtl/cq_dpram.sv
// Simple dual-port RAM holding left/right sample pairs; registered read, no array reset.
module cq_dpram
  import cq_pkg::*;
#(
  parameter  int DW    = CQ_DW,
  parameter  int DEPTH = CQ_DEPTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [PW-1:0]   i_waddr,
  input  logic [2*DW-1:0] i_wdata,
  input  logic [PW-1:0]   i_raddr,
  output logic [2*DW-1:0] o_rdata
);

  logic [2*DW-1:0] r_mem [DEPTH];
  logic [2*DW-1:0] r_rdata;

  // write port and one-cycle registered read port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cq_sequencer.sv
// Dual-channel circular sample queue: stores every incoming pair and, after each
// new pair, replays the newest TAPS pairs oldest-first under 'sequencing'.
// Optional feature macro: CQ_OVERRUN_FLAG_EN adds the sticky 'overrun' flag.
module cq_sequencer
  import cq_pkg::*;
#(
  parameter int DW    = CQ_DW,
  parameter int DEPTH = CQ_DEPTH,
  parameter int TAPS  = CQ_TAPS
) (
  input  logic           clk,
  input  logic           rst_n,
  cq_sequencer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + 1);

  localparam logic [CW-1:0] TAPS_C  = CW'(TAPS);
  localparam logic [CW-1:0] TAPS_M1 = CW'(TAPS - 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  // circular pointer advance, DEPTH need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  cq_state_t       r_state;
  cq_state_t       w_state_nxt;
  logic [PW-1:0]   r_new_ptr;
  logic [PW-1:0]   r_old_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_seq_cnt;
  logic            r_pending;
  logic            r_vld_p1;
  logic            w_full;
  logic [PW-1:0]   w_old_ptr_nxt;
  logic            w_seq_start;
  logic            w_pend_set;
  logic            w_pend_clr;
  logic [2*DW-1:0] w_rdata_p1;

  assign w_full        = (r_count == TAPS_C);
  // oldest-window pointer after this cycle's write; a new replay starts from here
  assign w_old_ptr_nxt = (bus.valid && w_full) ? ptr_inc(r_old_ptr) : r_old_ptr;

  // next-state and replay start/pending decisions
  always_comb begin
    w_state_nxt = r_state;
    w_seq_start = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    case (r_state)
      FILL: begin
        if (bus.valid && (r_count == TAPS_M1)) begin
          w_state_nxt = SEQ;
          w_seq_start = 1'b1;
        end
      end
      IDLE: begin
        if (bus.valid) begin
          w_state_nxt = SEQ;
          w_seq_start = 1'b1;
        end
      end
      SEQ: begin
        if (bus.valid) begin
          w_pend_set = 1'b1;
        end
        if (r_seq_cnt == TAPS_M1) begin
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        // a valid arriving in GAP is folded straight into the next replay
        if (r_pending || bus.valid) begin
          w_state_nxt = SEQ;
          w_seq_start = 1'b1;
          w_pend_clr  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // write side: head/tail pointers, fill count and pending-replay flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_new_ptr <= '0;
      r_old_ptr <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (bus.valid) begin
        r_new_ptr <= ptr_inc(r_new_ptr);
        r_old_ptr <= w_old_ptr_nxt;
        if (!w_full) begin
          r_count <= r_count + 1'b1;
        end
      end
      if (w_pend_clr) begin
        r_pending <= 1'b0;
      end else if (w_pend_set) begin
        r_pending <= 1'b1;
      end
    end
  end

  // stage p0: read address generation, window captured at replay entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr  <= '0;
      r_seq_cnt <= '0;
    end else if (w_seq_start) begin
      r_rd_ptr  <= w_old_ptr_nxt;
      r_seq_cnt <= '0;
    end else if (r_state == SEQ) begin
      r_rd_ptr  <= ptr_inc(r_rd_ptr);
      r_seq_cnt <= r_seq_cnt + 1'b1;
    end
  end

  cq_dpram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (bus.valid),
    .i_waddr (r_new_ptr),
    .i_wdata ({bus.lft_new, bus.rght_new}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata_p1)
  );

  // stage p1: valid tracks the RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= (r_state == SEQ);
    end
  end

  assign bus.sequencing = r_vld_p1;
  assign bus.lft_smpl   = r_vld_p1 ? w_rdata_p1[2*DW-1:DW] : '0;
  assign bus.rght_smpl  = r_vld_p1 ? w_rdata_p1[DW-1:0]    : '0;

`ifdef CQ_OVERRUN_FLAG_EN
  logic r_overrun;
  logic w_ovr_evt;

  // a second valid while a replay is already pending loses one replay
  assign w_ovr_evt = bus.valid && r_pending && ((r_state == SEQ) || (r_state == GAP));

  // sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_evt) begin
      r_overrun <= 1'b1;
    end
  end

  assign bus.overrun = r_overrun;
`endif

endmodule

// File: tb/tb_cq_sequencer.sv
// Scoreboard bench for cq_sequencer: expected replay samples are queued as pairs are
// sent and compared as the DUT replays them.
module tb_cq_sequencer;
  import cq_pkg::*;

  localparam int TAPS = CQ_TAPS;

  logic clk = 1'b0;
  logic rst_n;

  cq_sequencer_if #(.DW(CQ_DW)) bus ();

  cq_sequencer #(
    .DW    (CQ_DW),
    .DEPTH (CQ_DEPTH),
    .TAPS  (CQ_TAPS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int hist_l[$];
  int hist_r[$];
  int exp_l[$];
  int exp_r[$];
  int replays = 0;
  int exp_replays = 0;
  int run_len = 0;
  logic prev_seq = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic send(input int l, input int r);
    bus.valid    = 1'b1;
    bus.lft_new  = 16'(l);
    bus.rght_new = 16'(r);
    hist_l.push_back(l);
    hist_r.push_back(r);
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
  endtask

  // one replay of the newest TAPS pairs sent so far
  task automatic push_window();
    int n;
    n = hist_l.size();
    for (int i = n - TAPS; i < n; i++) begin
      exp_l.push_back(hist_l[i]);
      exp_r.push_back(hist_r[i]);
    end
    exp_replays++;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_l.size() != 0 || bus.sequencing) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", exp_l.size(), 0);
    wait_cycles(3);
    chk("replay_count", replays, exp_replays);
  endtask

  // monitor: compare replayed samples, zero outputs when idle, replay length
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len  = 0;
      prev_seq = 1'b0;
    end else begin
      if (bus.sequencing) begin
        if (!prev_seq) replays++;
        run_len++;
        chk("exp_avail", int'(exp_l.size() > 0), 1);
        if (exp_l.size() > 0) begin
          chk("lft_smpl", int'($signed(bus.lft_smpl)), exp_l.pop_front());
          chk("rght_smpl", int'($signed(bus.rght_smpl)), exp_r.pop_front());
        end
      end else begin
        chk("lft_idle", int'($signed(bus.lft_smpl)), 0);
        chk("rght_idle", int'($signed(bus.rght_smpl)), 0);
        if (run_len > 0) begin
          chk("run_len", run_len, TAPS);
          run_len = 0;
        end
      end
      prev_seq = bus.sequencing;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n        = 1'b0;
    bus.valid    = 1'b0;
    bus.lft_new  = '0;
    bus.rght_new = '0;
    wait_cycles(3);
    chk("rst_seq", int'(bus.sequencing), 0);
    chk("rst_lft", int'($signed(bus.lft_smpl)), 0);
    chk("rst_rght", int'($signed(bus.rght_smpl)), 0);
`ifdef CQ_OVERRUN_FLAG_EN
    chk("rst_ovr", int'(bus.overrun), 0);
`endif
    rst_n = 1'b1;
    wait_cycles(2);

    // fill: no replay before the window is full, then 1..1021
    for (int i = 1; i <= TAPS - 1; i++) send(i, i);
    wait_cycles(5);
    chk("fill_no_replay", replays, 0);
    send(TAPS, TAPS);
    push_window();
    chk("lat_lo", int'(bus.sequencing), 0);
    wait_cycles(1);
    chk("lat_hi", int'(bus.sequencing), 1);
    wait_done();

    // single new pair from IDLE: window slides by one
    send(1022, 1022);
    push_window();
    wait_done();

    // one valid mid-replay: current replay intact, one more replay ending 5000
    send(1023, 1023);
    push_window();
    wait_cycles(400);
    send(5000, 5000);
    push_window();
    wait_done();
`ifdef CQ_OVERRUN_FLAG_EN
    chk("ovr_single", int'(bus.overrun), 0);
`endif

    // two valids mid-replay: only one following replay, ending 6000,6001
    send(1024, 1024);
    push_window();
    wait_cycles(300);
    send(6000, 6000);
    send(6001, 6001);
    push_window();
    wait_done();
`ifdef CQ_OVERRUN_FLAG_EN
    chk("ovr_set", int'(bus.overrun), 1);
`endif

    // stream with R = -L, bursts push the pointers across the DEPTH wrap
    k = 2000;
    for (int it = 0; it < 3; it++) begin
      k++;
      send(k, -k);
      push_window();
      wait_cycles(20);
      for (int j = 0; j < 300; j++) begin
        k++;
        send(k, -k);
      end
      push_window();
      wait_done();
    end
`ifdef CQ_OVERRUN_FLAG_EN
    chk("ovr_sticky", int'(bus.overrun), 1);
`endif

    // reset mid-replay: outputs drop at once, queue treated as empty
    k++;
    send(k, k);
    push_window();
    wait_cycles(501);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_seq", int'(bus.sequencing), 0);
    chk("mid_rst_lft", int'($signed(bus.lft_smpl)), 0);
    chk("mid_rst_rght", int'($signed(bus.rght_smpl)), 0);
`ifdef CQ_OVERRUN_FLAG_EN
    chk("mid_rst_ovr", int'(bus.overrun), 0);
`endif
    exp_l.delete();
    exp_r.delete();
    hist_l.delete();
    hist_r.delete();
    replays     = 0;
    exp_replays = 0;
    wait_cycles(1);
    rst_n = 1'b1;
    wait_cycles(1);
    for (int i = 1; i <= TAPS - 1; i++) send(7000 + i, -(7000 + i));
    wait_cycles(5);
    chk("refill_no_replay", replays, 0);
    send(7000 + TAPS, -(7000 + TAPS));
    push_window();
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
